// File: rtl/jtframe_dump_trigger.sv
// jtframe_dump_trigger: frame counter and dump-window control derived from vs falling edges.
// Latency: vs sampled low first at edge N -> every output updates together at edge N+2.
// Backpressure: none; free-running observer. Optional macro JTFRAME_DUMP_LOADROM_EN arms after ROM download.
module jtframe_dump_trigger #(
  parameter int CW          = 32,
  parameter int START_FRAME = 0,
  parameter int DUMP_FRAMES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vs,
  input  logic          downloading,
  output logic [CW-1:0] frame_cnt,
  output logic          vs_fall,
  output logic          dump_en,
  output logic          dump_start,
  output logic          dump_stop,
  output logic [15:0]   dumped,
  output logic [1:0]    st
);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DUMP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] START_W = CW'(START_FRAME);
  localparam logic [15:0]   DUMP_W  = 16'(DUMP_FRAMES);
  localparam bit            LIMITED = (DUMP_FRAMES != 0);

  logic          vs_s1_q, vs_s2_q, vs_prev_q;
  logic          fall_w;
  logic          force_wait_w;
  logic          arm_w;
  logic [CW-1:0] cnt_d;
  logic [15:0]   dumped_d;

  state_t        st_q;
  logic [CW-1:0] frame_cnt_q;
  logic          vs_fall_q, dump_en_q, dump_start_q, dump_stop_q;
  logic [15:0]   dumped_q;

  // Two-flop synchronizer for vs plus a delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_s1_q   <= 1'b0;
      vs_s2_q   <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      vs_s1_q   <= vs;
      vs_s2_q   <= vs_s1_q;
      vs_prev_q <= vs_s2_q;
    end
  end

  assign fall_w = vs_prev_q & ~vs_s2_q;

`ifdef JTFRAME_DUMP_LOADROM_EN
  logic dl_q, dl_prev_q;

  // Register downloading once, then keep one more copy to find its falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_q      <= 1'b0;
      dl_prev_q <= 1'b0;
    end else begin
      dl_q      <= downloading;
      dl_prev_q <= dl_q;
    end
  end

  // A download in progress overrides everything; arming waits for the download to end.
  assign force_wait_w = downloading;
  assign arm_w        = dl_prev_q & ~dl_q;
`else
  logic unused_downloading;
  assign unused_downloading = downloading;

  // Without download gating the block arms straight after reset.
  assign force_wait_w = 1'b0;
  assign arm_w        = 1'b1;
`endif

  // Saturating increments: counters stick at all-ones instead of wrapping.
  always_comb begin
    cnt_d    = (&frame_cnt_q) ? frame_cnt_q : frame_cnt_q + CW'(1);
    dumped_d = (&dumped_q)    ? dumped_q    : dumped_q + 16'd1;
  end

  // Trigger FSM; all outputs are registered here so they move on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q         <= ST_WAIT;
      frame_cnt_q  <= '0;
      vs_fall_q    <= 1'b0;
      dump_en_q    <= 1'b0;
      dump_start_q <= 1'b0;
      dump_stop_q  <= 1'b0;
      dumped_q     <= '0;
    end else begin
      vs_fall_q    <= fall_w;
      dump_start_q <= 1'b0;
      dump_stop_q  <= 1'b0;
      if (force_wait_w) begin
        // Leaving an open window still reports its closing.
        st_q        <= ST_WAIT;
        frame_cnt_q <= '0;
        dumped_q    <= '0;
        dump_en_q   <= 1'b0;
        dump_stop_q <= (st_q == ST_DUMP);
      end else begin
        case (st_q)
          ST_WAIT: begin
            frame_cnt_q <= '0;
            if (arm_w) st_q <= ST_ARMED;
          end
          ST_ARMED: begin
            if (fall_w) begin
              frame_cnt_q <= cnt_d;
              // Compare the count before this frame is added.
              if (frame_cnt_q == START_W) begin
                st_q         <= ST_DUMP;
                dump_en_q    <= 1'b1;
                dump_start_q <= 1'b1;
                dumped_q     <= '0;
              end
            end
          end
          ST_DUMP: begin
            if (fall_w) begin
              frame_cnt_q <= cnt_d;
              dumped_q    <= dumped_d;
              if (LIMITED && dumped_d == DUMP_W) begin
                st_q        <= ST_DONE;
                dump_en_q   <= 1'b0;
                dump_stop_q <= 1'b1;
              end
            end
          end
          default: begin
            if (fall_w) frame_cnt_q <= cnt_d;
          end
        endcase
      end
    end
  end

  assign st         = st_q;
  assign frame_cnt  = frame_cnt_q;
  assign vs_fall    = vs_fall_q;
  assign dump_en    = dump_en_q;
  assign dump_start = dump_start_q;
  assign dump_stop  = dump_stop_q;
  assign dumped     = dumped_q;

endmodule
